// File: rtl/spi_reg_pkg.sv
// Shared register map, bit positions and address decode for the SPI register file.
package spi_reg_pkg;

    localparam logic [11:0] REG_CTRL   = 12'h000;
    localparam logic [11:0] REG_STATUS = 12'h004;
    localparam logic [11:0] REG_CLKDIV = 12'h008;
    localparam logic [11:0] REG_TXDATA = 12'h00C;
    localparam logic [11:0] REG_RXDATA = 12'h010;
    localparam logic [11:0] REG_LEVEL  = 12'h014;
    localparam logic [11:0] ADDR_LIMIT = 12'h018;

    // CTRL bit positions
    localparam int CTRL_EN     = 0;
    localparam int CTRL_CPOL   = 1;
    localparam int CTRL_CPHA   = 2;
    localparam int CTRL_LSB    = 3;
    localparam int CTRL_FLUSH  = 4;
    localparam int CTRL_IE_RX  = 6;
    localparam int CTRL_IE_TX  = 7;
    localparam int CTRL_IE_OVF = 8;

    // FLUSH (bit 4) and bit 5 are never stored
    localparam logic [8:0] CTRL_WMASK = 9'h1CF;

    // STATUS bit positions
    localparam int STAT_TX_FULL  = 0;
    localparam int STAT_TX_EMPTY = 1;
    localparam int STAT_RX_FULL  = 2;
    localparam int STAT_RX_EMPTY = 3;
    localparam int STAT_BUSY     = 4;
    localparam int STAT_RX_OVF   = 5;

    localparam logic [7:0] CLKDIV_RST_DEF = 8'h04;

    typedef enum logic [2:0] {
        SEL_CTRL,
        SEL_STATUS,
        SEL_CLKDIV,
        SEL_TXDATA,
        SEL_RXDATA,
        SEL_LEVEL,
        SEL_NONE
    } reg_sel_e;

    // Map an offset to a register; misaligned or out-of-range offsets give SEL_NONE
    function automatic reg_sel_e decode_addr(input logic [11:0] addr);
        if (addr >= ADDR_LIMIT || addr[1:0] != 2'b00) begin
            return SEL_NONE;
        end
        case (addr[4:2])
            3'd0:    return SEL_CTRL;
            3'd1:    return SEL_STATUS;
            3'd2:    return SEL_CLKDIV;
            3'd3:    return SEL_TXDATA;
            3'd4:    return SEL_RXDATA;
            3'd5:    return SEL_LEVEL;
            default: return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. A push into a full FIFO is accepted when a pop happens in
// the same cycle; flush overrides both and leaves the FIFO empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_data  = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; pointers wrap naturally (power-of-two depth)
    always_comb begin
        pop_ok   = i_pop & ~o_empty;
        push_ok  = i_push & (~o_full | pop_ok);
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Control state: pointers and count
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

endmodule

// File: rtl/spi_regfile.sv
// APB-facing register file for the SPI block: control/config registers,
// TX/RX byte FIFOs, zero-wait-state read mux, access error and interrupt.
module spi_regfile
    import spi_reg_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] CLKDIV_RST = CLKDIV_RST_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [11:0] i_addr,
    input  logic        i_wr_en,
    input  logic        i_rd_en,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_error,
    output logic        o_spi_en,
    output logic        o_cpol,
    output logic        o_cpha,
    output logic        o_lsb_first,
    output logic [7:0]  o_clk_div,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_ready,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    input  logic        i_busy,
    output logic        o_irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [8:0]    ctrl_q, ctrl_d;
    logic [7:0]    clk_div_q, clk_div_d;
    logic          rx_ovf_q, rx_ovf_d;

    reg_sel_e      sel;
    logic          tx_push, tx_pop, rx_pop, flush;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0]    tx_head, rx_head;
    logic [CW-1:0] tx_count, rx_count;
    logic [31:0]   status_w, level_w;
    logic          unused_wdata;

    assign unused_wdata = ^i_wdata[31:9];

    assign o_spi_en    = ctrl_q[CTRL_EN];
    assign o_cpol      = ctrl_q[CTRL_CPOL];
    assign o_cpha      = ctrl_q[CTRL_CPHA];
    assign o_lsb_first = ctrl_q[CTRL_LSB];
    assign o_clk_div   = clk_div_q;
    assign o_tx_valid  = ~tx_empty & ctrl_q[CTRL_EN];
    // Head byte is forced to 0 while empty so stale storage never leaks out
    assign o_tx_data   = tx_empty ? 8'h00 : tx_head;
    assign tx_pop      = o_tx_valid & i_tx_ready;

    assign o_irq = (ctrl_q[CTRL_IE_RX]  & ~rx_empty)
                 | (ctrl_q[CTRL_IE_TX]  &  tx_empty)
                 | (ctrl_q[CTRL_IE_OVF] &  rx_ovf_q);

    assign status_w = {26'b0, rx_ovf_q, i_busy, rx_empty, rx_full, tx_empty, tx_full};
    assign level_w  = (32'(rx_count) << 8) | 32'(tx_count);

    // Decode, read mux, FIFO strobes, error flag and register next-state
    always_comb begin
        sel       = decode_addr(i_addr);
        o_rdata   = 32'h0;
        tx_push   = i_wr_en & (sel == SEL_TXDATA);
        rx_pop    = i_rd_en & (sel == SEL_RXDATA) & ~rx_empty;
        flush     = i_wr_en & (sel == SEL_CTRL) & i_wdata[CTRL_FLUSH];
        ctrl_d    = ctrl_q;
        clk_div_d = clk_div_q;
        rx_ovf_d  = rx_ovf_q;

        if (i_rd_en) begin
            case (sel)
                SEL_CTRL:   o_rdata = {23'b0, ctrl_q};
                SEL_STATUS: o_rdata = status_w;
                SEL_CLKDIV: o_rdata = {24'b0, clk_div_q};
                SEL_RXDATA: o_rdata = rx_empty ? 32'h0 : {24'b0, rx_head};
                SEL_LEVEL:  o_rdata = level_w;
                default:    o_rdata = 32'h0;
            endcase
        end

        o_error = ((i_wr_en | i_rd_en) & (sel == SEL_NONE))
                | (i_wr_en & ((sel == SEL_RXDATA) | (sel == SEL_LEVEL)))
                | (tx_push & tx_full & ~tx_pop)
                | (i_rd_en & (sel == SEL_RXDATA) & rx_empty);

        if (i_wr_en && sel == SEL_CTRL) begin
            ctrl_d = i_wdata[8:0] & CTRL_WMASK;
        end
        if (i_wr_en && sel == SEL_CLKDIV) begin
            clk_div_d = i_wdata[7:0];
        end
        // W1C clear first so a same-cycle overflow set takes priority
        if (i_wr_en && sel == SEL_STATUS && i_wdata[STAT_RX_OVF]) begin
            rx_ovf_d = 1'b0;
        end
        if (i_rx_valid && rx_full && !rx_pop) begin
            rx_ovf_d = 1'b1;
        end
    end

    // Register state update
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ctrl_q    <= '0;
            clk_div_q <= CLKDIV_RST;
            rx_ovf_q  <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            clk_div_q <= clk_div_d;
            rx_ovf_q  <= rx_ovf_d;
        end
    end

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (tx_push),
        .i_data  (i_wdata[7:0]),
        .i_pop   (tx_pop),
        .i_flush (flush),
        .o_data  (tx_head),
        .o_full  (tx_full),
        .o_empty (tx_empty),
        .o_count (tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_rx_valid),
        .i_data  (i_rx_data),
        .i_pop   (rx_pop),
        .i_flush (flush),
        .o_data  (rx_head),
        .o_full  (rx_full),
        .o_empty (rx_empty),
        .o_count (rx_count)
    );

endmodule

// File: tb/tb_spi_regfile.sv
// Scoreboard bench for spi_regfile: stimulus queues expected bus responses and
// pin snapshots; a monitor compares them on the falling edge.
module tb_spi_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] addr;
    logic        wr_en, rd_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        error;
    logic        spi_en, cpol, cpha, lsb_first;
    logic [7:0]  clk_div;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        busy;
    logic        irq;
    logic        probe;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
    } bus_exp_t;

    typedef struct {
        string      name;
        logic [3:0] mode;      // {lsb_first, cpha, cpol, spi_en}
        logic [7:0] clk_div;
        logic       tx_valid;
        logic [7:0] tx_data;
        logic       irq;
    } pin_exp_t;

    bus_exp_t bus_q[$];
    pin_exp_t pin_q[$];

    always #5 clk = ~clk;

    spi_regfile #(.FIFO_DEPTH(4), .CLKDIV_RST(8'h04)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_addr      (addr),
        .i_wr_en     (wr_en),
        .i_rd_en     (rd_en),
        .i_wdata     (wdata),
        .o_rdata     (rdata),
        .o_error     (error),
        .o_spi_en    (spi_en),
        .o_cpol      (cpol),
        .o_cpha      (cpha),
        .o_lsb_first (lsb_first),
        .o_clk_div   (clk_div),
        .o_tx_valid  (tx_valid),
        .o_tx_data   (tx_data),
        .i_tx_ready  (tx_ready),
        .i_rx_valid  (rx_valid),
        .i_rx_data   (rx_data),
        .i_busy      (busy),
        .o_irq       (irq)
    );

    // Monitor: compare whenever the DUT sees a strobe or the stimulus asks for a pin snapshot
    always @(negedge clk) begin
        if (wr_en || rd_en) begin
            checks++;
            if (bus_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: no expectation queued at addr %h", addr);
            end else begin
                bus_exp_t e;
                e = bus_q.pop_front();
                if (rdata !== e.rdata || error !== e.err) begin
                    errors++;
                    $display("FAIL %s: got rdata=%h err=%b, expected rdata=%h err=%b",
                             e.name, rdata, error, e.rdata, e.err);
                end
            end
        end
        if (probe) begin
            checks++;
            if (pin_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_probe: no pin expectation queued");
            end else begin
                pin_exp_t p;
                logic [3:0] mode;
                p = pin_q.pop_front();
                mode = {lsb_first, cpha, cpol, spi_en};
                if (mode !== p.mode || clk_div !== p.clk_div || tx_valid !== p.tx_valid ||
                    tx_data !== p.tx_data || irq !== p.irq) begin
                    errors++;
                    $display("FAIL %s: got mode=%h div=%h txv=%b txd=%h irq=%b, expected mode=%h div=%h txv=%b txd=%h irq=%b",
                             p.name, mode, clk_div, tx_valid, tx_data, irq,
                             p.mode, p.clk_div, p.tx_valid, p.tx_data, p.irq);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [11:0] a, input logic [31:0] d, input logic exp_err, input string name);
        bus_q.push_back('{name, 32'h0, exp_err});
        addr = a; wdata = d; wr_en = 1'b1;
        step();
        wr_en = 1'b0; wdata = 32'h0;
    endtask

    task automatic bus_rd(input logic [11:0] a, input logic [31:0] exp_d, input logic exp_err, input string name);
        bus_q.push_back('{name, exp_d, exp_err});
        addr = a; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic pins(input logic [3:0] m, input logic [7:0] div, input logic txv,
                        input logic [7:0] txd, input logic ir, input string name);
        pin_q.push_back('{name, m, div, txv, txd, ir});
        probe = 1'b1;
        step();
        probe = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        step();
        rx_valid = 1'b0;
    endtask

    // Guard against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; addr = '0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0; busy = 1'b0; probe = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset state
        pins(4'h0, 8'h04, 1'b0, 8'h00, 1'b0, "reset_pins");
        bus_rd(12'h000, 32'h0,  1'b0, "reset_ctrl");
        bus_rd(12'h004, 32'h0A, 1'b0, "reset_status");
        bus_rd(12'h008, 32'h04, 1'b0, "reset_clkdiv");
        bus_rd(12'h014, 32'h0,  1'b0, "reset_level");

        // Control/config writes
        bus_wr(12'h000, 32'h0F, 1'b0, "wr_ctrl");
        bus_wr(12'h008, 32'h10, 1'b0, "wr_clkdiv");
        pins(4'hF, 8'h10, 1'b0, 8'h00, 1'b0, "cfg_pins");
        bus_rd(12'h000, 32'h0F, 1'b0, "rd_ctrl");

        // TX fill with EN=0
        bus_wr(12'h000, 32'h0E, 1'b0, "ctrl_en_off");
        for (int i = 0; i < 4; i++) begin
            bus_wr(12'h00C, 32'hA1 + i, 1'b0, "tx_push");
        end
        bus_rd(12'h014, 32'h4,  1'b0, "level_tx4");
        bus_rd(12'h004, 32'h09, 1'b0, "status_tx_full");
        bus_wr(12'h00C, 32'hA5, 1'b1, "tx_push_full");
        pins(4'hE, 8'h10, 1'b0, 8'hA1, 1'b0, "tx_held_en_off");

        // Drain TX with EN=1
        bus_wr(12'h000, 32'h0F, 1'b0, "ctrl_en_on");
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pins(4'hF, 8'h10, 1'b1, 8'hA1 + 8'(i), 1'b0, "tx_drain");
        end
        tx_ready = 1'b0;
        pins(4'hF, 8'h10, 1'b0, 8'h00, 1'b0, "tx_drained");

        // RX overflow
        for (int i = 0; i < 5; i++) begin
            rx_byte(8'h11 + 8'(i));
        end
        bus_rd(12'h004, 32'h26,  1'b0, "status_rx_ovf");
        bus_rd(12'h014, 32'h400, 1'b0, "level_rx4");
        for (int i = 0; i < 4; i++) begin
            bus_rd(12'h010, 32'h11 + i, 1'b0, "rx_pop");
        end
        bus_rd(12'h010, 32'h0,  1'b1, "rx_pop_empty");
        bus_rd(12'h004, 32'h2A, 1'b0, "status_ovf_sticky");
        bus_wr(12'h004, 32'h20, 1'b0, "status_w1c");
        bus_rd(12'h004, 32'h0A, 1'b0, "status_ovf_clear");

        // Decode errors without side effects
        bus_rd(12'h018, 32'h0, 1'b1, "rd_0x018");
        bus_rd(12'hFFC, 32'h0, 1'b1, "rd_0xFFC");
        bus_rd(12'h002, 32'h0, 1'b1, "rd_0x002");
        bus_wr(12'h010, 32'h55, 1'b1, "wr_rxdata");
        bus_wr(12'h014, 32'h55, 1'b1, "wr_level");
        bus_wr(12'h002, 32'h0,  1'b1, "wr_misaligned");
        bus_rd(12'h000, 32'h0F, 1'b0, "ctrl_unchanged");
        bus_rd(12'h014, 32'h0,  1'b0, "level_unchanged");

        // RX full with simultaneous engine push and bus pop
        for (int i = 0; i < 4; i++) begin
            rx_byte(8'h21 + 8'(i));
        end
        rx_valid = 1'b1; rx_data = 8'h25;
        bus_rd(12'h010, 32'h21, 1'b0, "rx_pop_push_full");
        rx_valid = 1'b0;
        busy = 1'b1;
        bus_rd(12'h004, 32'h16, 1'b0, "status_full_no_ovf_busy");
        busy = 1'b0;

        // TX full with simultaneous engine pop and bus push
        for (int i = 0; i < 4; i++) begin
            bus_wr(12'h00C, 32'hB1 + i, 1'b0, "tx_push_en");
        end
        tx_ready = 1'b1;
        bus_wr(12'h00C, 32'hB5, 1'b0, "tx_push_full_pop");
        tx_ready = 1'b0;
        bus_rd(12'h014, 32'h404, 1'b0, "level_both_full");
        pins(4'hF, 8'h10, 1'b1, 8'hB2, 1'b0, "tx_head_after_pop");

        // Flush both FIFOs with IE_TX set
        bus_wr(12'h000, 32'h9F, 1'b0, "ctrl_flush");
        pins(4'hF, 8'h10, 1'b0, 8'h00, 1'b1, "flush_irq_tx");
        bus_rd(12'h014, 32'h0,  1'b0, "level_flushed");
        bus_rd(12'h000, 32'h8F, 1'b0, "ctrl_flush_reads0");
        bus_rd(12'h010, 32'h0,  1'b1, "rx_empty_after_flush");

        // RX interrupt
        bus_wr(12'h000, 32'h4F, 1'b0, "ctrl_ie_rx");
        pins(4'hF, 8'h10, 1'b0, 8'h00, 1'b0, "irq_rx_idle");
        rx_byte(8'h77);
        pins(4'hF, 8'h10, 1'b0, 8'h00, 1'b1, "irq_rx_pending");
        bus_rd(12'h010, 32'h77, 1'b0, "rx_irq_byte");

        repeat (2) step();
        checks++;
        if (bus_q.size() != 0 || pin_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d bus and %0d pin expectations left, required 0",
                     bus_q.size(), pin_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
